// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU even-pipe operand fetch stage.
// Register addresses, opcodes and data words are numbered big-endian (bit 0 is the MSB).
package spu_pkg;

    localparam int QUAD_W     = 128;
    localparam int REG_ADDR_W = 7;
    localparam int OPC_W      = 11;
    localparam int IMM_W      = 18;
    localparam int FMT_W      = 3;
    localparam int NUM_SRC    = 3;

    localparam logic [0:OPC_W-1] NOP_OPC = 11'b0;

    typedef logic [0:QUAD_W-1]     quad_t;
    typedef logic [0:REG_ADDR_W-1] reg_addr_t;

    // One delayed result stage of an execution unit, as seen by the forwarding network.
    typedef struct packed {
        reg_addr_t addr;
        logic      en;
        logic      rdy;
        quad_t     data;
    } fwd_stage_t;

    // Everything the output register presents to the execution units.
    typedef struct packed {
        logic [0:OPC_W-1] op_code;
        logic [FMT_W-1:0] instr_format;
        reg_addr_t        dest_reg_addr;
        logic             enable_reg_write;
        logic [0:IMM_W-1] imm_value;
        quad_t            src_a;
        quad_t            src_b;
        quad_t            src_c;
    } issue_t;

    // All-zero issue word: format 0 / opcode 0 is the nop the units ignore.
    function automatic issue_t nop_issue();
        issue_t n;
        n         = '0;
        n.op_code = NOP_OPC;
        return n;
    endfunction

    function automatic logic stage_hits(input fwd_stage_t st, input reg_addr_t addr);
        return st.en && (st.addr == addr);
    endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Resolves one source register: stall on an issued or not-yet-ready producer,
// else the youngest forwarded result, else register-file data.
module operand_forward_mux
    import spu_pkg::*;
#(
    parameter int NUM_UNITS  = 3,
    parameter int FWD_STAGES = 4
) (
    input  logic       uses_i,
    input  reg_addr_t  src_addr_i,
    input  logic       issued_en_i,
    input  reg_addr_t  issued_addr_i,
    input  quad_t      rf_data_i,
    input  fwd_stage_t fwd_i [NUM_UNITS][FWD_STAGES],
    output quad_t      data_o,
    output logic       stall_o
);

    logic  hit;
    logic  hit_rdy;
    quad_t hit_data;

    // Scan oldest-to-youngest and highest-to-lowest unit so the last match wins:
    // that leaves the lowest stage, then the lowest unit, in hit_*.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int s = FWD_STAGES - 1; s >= 0; s--) begin
            for (int u = NUM_UNITS - 1; u >= 0; u--) begin
                if (stage_hits(fwd_i[u][s], src_addr_i)) begin
                    hit      = 1'b1;
                    hit_rdy  = fwd_i[u][s].rdy;
                    hit_data = fwd_i[u][s].data;
                end
            end
        end
    end

    always_comb begin
        data_o  = rf_data_i;
        stall_o = 1'b0;
        if (uses_i) begin
            // The instruction sitting in the output register has not reached any unit stage yet.
            if (issued_en_i && (issued_addr_i == src_addr_i)) begin
                stall_o = 1'b1;
            end else if (hit) begin
                if (hit_rdy) begin
                    data_o = hit_data;
                end else begin
                    stall_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/even_operand_fetch.sv
// Even-pipe register fetch / forwarding stage: resolves ra/rb/rc, stalls on RAW
// hazards, drops instructions on a taken branch and registers operands for the units.
module even_operand_fetch
    import spu_pkg::*;
#(
    parameter int NUM_UNITS  = 3,
    parameter int FWD_STAGES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:OPC_W-1]      in_op_code,
    input  logic [FMT_W-1:0]      in_instr_format,
    input  logic [0:REG_ADDR_W-1] in_rt,
    input  logic [0:REG_ADDR_W-1] in_ra,
    input  logic [0:REG_ADDR_W-1] in_rb,
    input  logic [0:REG_ADDR_W-1] in_rc,
    input  logic                  in_uses_ra,
    input  logic                  in_uses_rb,
    input  logic                  in_uses_rc,
    input  logic [0:IMM_W-1]      in_imm_value,
    input  logic                  in_enable_reg_write,
    input  logic [0:QUAD_W-1]     rf_ra_data,
    input  logic [0:QUAD_W-1]     rf_rb_data,
    input  logic [0:QUAD_W-1]     rf_rc_data,
    input  logic [0:REG_ADDR_W-1] fwd_addr [NUM_UNITS][FWD_STAGES],
    input  logic                  fwd_en   [NUM_UNITS][FWD_STAGES],
    input  logic                  fwd_rdy  [NUM_UNITS][FWD_STAGES],
    input  logic [0:QUAD_W-1]     fwd_data [NUM_UNITS][FWD_STAGES],
    input  logic                  branch_is_taken,
    output logic [0:OPC_W-1]      op_code,
    output logic [FMT_W-1:0]      instr_format,
    output logic [0:REG_ADDR_W-1] dest_reg_addr,
    output logic                  enable_reg_write,
    output logic [0:IMM_W-1]      imm_value,
    output logic [0:QUAD_W-1]     src_reg_a,
    output logic [0:QUAD_W-1]     src_reg_b,
    output logic [0:QUAD_W-1]     src_reg_c,
    output logic [31:0]           stall_count
);

    fwd_stage_t           fwd_stage [NUM_UNITS][FWD_STAGES];
    reg_addr_t            src_addr  [NUM_SRC];
    logic                 src_uses  [NUM_SRC];
    quad_t                src_rf    [NUM_SRC];
    quad_t                src_data  [NUM_SRC];
    logic [NUM_SRC-1:0]   src_stall;

    issue_t               issue_q, issue_d;
    logic [31:0]          stall_count_q, stall_count_d;
    logic                 stall;
    logic                 accept;

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int s = 0; s < FWD_STAGES; s++) begin
                fwd_stage[u][s].addr = fwd_addr[u][s];
                fwd_stage[u][s].en   = fwd_en[u][s];
                fwd_stage[u][s].rdy  = fwd_rdy[u][s];
                fwd_stage[u][s].data = fwd_data[u][s];
            end
        end
    end

    assign src_addr[0] = in_ra;
    assign src_addr[1] = in_rb;
    assign src_addr[2] = in_rc;
    assign src_uses[0] = in_uses_ra;
    assign src_uses[1] = in_uses_rb;
    assign src_uses[2] = in_uses_rc;
    assign src_rf[0]   = rf_ra_data;
    assign src_rf[1]   = rf_rb_data;
    assign src_rf[2]   = rf_rc_data;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        operand_forward_mux #(
            .NUM_UNITS  (NUM_UNITS),
            .FWD_STAGES (FWD_STAGES)
        ) u_mux (
            .uses_i        (src_uses[i]),
            .src_addr_i    (src_addr[i]),
            .issued_en_i   (issue_q.enable_reg_write),
            .issued_addr_i (issue_q.dest_reg_addr),
            .rf_data_i     (src_rf[i]),
            .fwd_i         (fwd_stage),
            .data_o        (src_data[i]),
            .stall_o       (src_stall[i])
        );
    end

    // A taken branch discards the instruction, so it can neither stall nor be counted.
    assign stall    = in_valid && !branch_is_taken && (|src_stall);
    assign accept   = in_valid && !branch_is_taken && !stall;
    assign in_ready = !stall;

    always_comb begin
        issue_d = nop_issue();
        if (accept) begin
            issue_d.op_code          = in_op_code;
            issue_d.instr_format     = in_instr_format;
            issue_d.dest_reg_addr    = in_rt;
            issue_d.enable_reg_write = in_enable_reg_write;
            issue_d.imm_value        = in_imm_value;
            issue_d.src_a            = src_data[0];
            issue_d.src_b            = src_data[1];
            issue_d.src_c            = src_data[2];
        end
    end

    assign stall_count_d = (stall && (stall_count_q != 32'hFFFF_FFFF)) ? stall_count_q + 32'd1
                                                                        : stall_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_q       <= '0;
            stall_count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            issue_q       <= issue_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign op_code          = issue_q.op_code;
    assign instr_format     = issue_q.instr_format;
    assign dest_reg_addr    = issue_q.dest_reg_addr;
    assign enable_reg_write = issue_q.enable_reg_write;
    assign imm_value        = issue_q.imm_value;
    assign src_reg_a        = issue_q.src_a;
    assign src_reg_b        = issue_q.src_b;
    assign src_reg_c        = issue_q.src_c;
    assign stall_count      = stall_count_q;

endmodule

// File: tb/tb_even_operand_fetch.sv
// Self-checking bench for even_operand_fetch: table-driven single-cycle vectors
// plus hand-written multi-cycle hazard, flush and reset sequences, via a scoreboard queue.
module tb_even_operand_fetch;
    import spu_pkg::*;

    localparam int NU = 3;
    localparam int NS = 4;

    localparam quad_t RA = {4{32'hA0A0_A0A0}};
    localparam quad_t RB = {4{32'hB0B0_B0B0}};
    localparam quad_t RC = {4{32'hC0C0_C0C0}};
    localparam quad_t D1 = {4{32'h1111_1111}};
    localparam quad_t D2 = {4{32'h2222_2222}};
    localparam quad_t D3 = {4{32'h3333_3333}};
    localparam quad_t D4 = {4{32'h4444_4444}};
    localparam quad_t D5 = {4{32'h5555_5555}};
    localparam quad_t DZ = '0;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  in_valid, in_ready;
    logic [0:OPC_W-1]      in_op_code;
    logic [FMT_W-1:0]      in_instr_format;
    logic [0:REG_ADDR_W-1] in_rt, in_ra, in_rb, in_rc;
    logic                  in_uses_ra, in_uses_rb, in_uses_rc;
    logic [0:IMM_W-1]      in_imm_value;
    logic                  in_enable_reg_write;
    quad_t                 rf_ra_data, rf_rb_data, rf_rc_data;
    logic [0:REG_ADDR_W-1] fwd_addr [NU][NS];
    logic                  fwd_en   [NU][NS];
    logic                  fwd_rdy  [NU][NS];
    quad_t                 fwd_data [NU][NS];
    logic                  branch_is_taken;
    logic [0:OPC_W-1]      op_code;
    logic [FMT_W-1:0]      instr_format;
    logic [0:REG_ADDR_W-1] dest_reg_addr;
    logic                  enable_reg_write;
    logic [0:IMM_W-1]      imm_value;
    quad_t                 src_reg_a, src_reg_b, src_reg_c;
    logic [31:0]           stall_count;

    always #5 clock = ~clock;

    even_operand_fetch #(.NUM_UNITS(NU), .FWD_STAGES(NS)) dut (
        .clock               (clock),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_op_code          (in_op_code),
        .in_instr_format     (in_instr_format),
        .in_rt               (in_rt),
        .in_ra               (in_ra),
        .in_rb               (in_rb),
        .in_rc               (in_rc),
        .in_uses_ra          (in_uses_ra),
        .in_uses_rb          (in_uses_rb),
        .in_uses_rc          (in_uses_rc),
        .in_imm_value        (in_imm_value),
        .in_enable_reg_write (in_enable_reg_write),
        .rf_ra_data          (rf_ra_data),
        .rf_rb_data          (rf_rb_data),
        .rf_rc_data          (rf_rc_data),
        .fwd_addr            (fwd_addr),
        .fwd_en              (fwd_en),
        .fwd_rdy             (fwd_rdy),
        .fwd_data            (fwd_data),
        .branch_is_taken     (branch_is_taken),
        .op_code             (op_code),
        .instr_format        (instr_format),
        .dest_reg_addr       (dest_reg_addr),
        .enable_reg_write    (enable_reg_write),
        .imm_value           (imm_value),
        .src_reg_a           (src_reg_a),
        .src_reg_b           (src_reg_b),
        .src_reg_c           (src_reg_c),
        .stall_count         (stall_count)
    );

    typedef struct {
        logic [0:OPC_W-1]      opc;
        logic [FMT_W-1:0]      fmt;
        logic [0:REG_ADDR_W-1] rt;
        logic                  we;
        logic [0:IMM_W-1]      imm;
        quad_t                 a, b, c;
    } exp_t;

    typedef struct {
        logic                  valid, branch;
        logic [0:REG_ADDR_W-1] ra, rb, rc;
        logic [2:0]            uses;      // {a, b, c}
        int                    f0u, f0s;
        logic [0:REG_ADDR_W-1] f0addr;
        logic                  f0en, f0rdy;
        quad_t                 f0data;
        int                    f1u, f1s;
        logic [0:REG_ADDR_W-1] f1addr;
        logic                  f1en, f1rdy;
        quad_t                 f1data;
        logic                  exp_ready, exp_issue;
        quad_t                 ea, eb, ec;
    } vec_t;

    exp_t sb_q [$];
    int   total_checks = 0;
    int   passed_checks = 0;
    int   exp_stalls = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk_exp(input logic [0:OPC_W-1] opc, input logic [FMT_W-1:0] fmt,
                                    input logic [0:REG_ADDR_W-1] rt, input logic we,
                                    input logic [0:IMM_W-1] imm, input quad_t a, input quad_t b,
                                    input quad_t c);
        exp_t e;
        e.opc = opc; e.fmt = fmt; e.rt = rt; e.we = we; e.imm = imm;
        e.a = a; e.b = b; e.c = c;
        return e;
    endfunction

    function automatic exp_t bubble();
        return mk_exp('0, '0, '0, 1'b0, '0, DZ, DZ, DZ);
    endfunction

    task automatic clear_fwd();
        for (int u = 0; u < NU; u++) begin
            for (int s = 0; s < NS; s++) begin
                fwd_addr[u][s] = '0;
                fwd_en[u][s]   = 1'b0;
                fwd_rdy[u][s]  = 1'b0;
                fwd_data[u][s] = '0;
            end
        end
    endtask

    task automatic set_fwd(input int u, input int s, input logic [0:REG_ADDR_W-1] addr,
                           input logic en, input logic rdy, input quad_t data);
        fwd_addr[u][s] = addr;
        fwd_en[u][s]   = en;
        fwd_rdy[u][s]  = rdy;
        fwd_data[u][s] = data;
    endtask

    task automatic set_instr(input logic v, input logic [0:OPC_W-1] opc,
                             input logic [0:REG_ADDR_W-1] rt, input logic we,
                             input logic [0:REG_ADDR_W-1] ra, input logic ua);
        in_valid            = v;
        in_op_code          = opc;
        in_instr_format     = 3'd2;
        in_rt               = rt;
        in_enable_reg_write = we;
        in_imm_value        = 18'h2_0000 | 18'(opc);
        in_ra               = ra;
        in_rb               = 7'd100;
        in_rc               = 7'd101;
        in_uses_ra          = ua;
        in_uses_rb          = 1'b0;
        in_uses_rc          = 1'b0;
    endtask

    // Inputs are already driven; checks in_ready mid-cycle, then the registered result after the edge.
    task automatic run_cycle(input string tag, input logic exp_ready, input exp_t e);
        exp_t got;
        #2;
        check({tag, "_in_ready"}, 128'(in_ready), 128'(exp_ready));
        if (!exp_ready) exp_stalls++;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        check({tag, "_sb_nonempty"}, 128'(sb_q.size() != 0), 128'(1));
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check({tag, "_op_code"}, 128'(op_code), 128'(got.opc));
            check({tag, "_instr_format"}, 128'(instr_format), 128'(got.fmt));
            check({tag, "_dest_reg_addr"}, 128'(dest_reg_addr), 128'(got.rt));
            check({tag, "_enable_reg_write"}, 128'(enable_reg_write), 128'(got.we));
            check({tag, "_imm_value"}, 128'(imm_value), 128'(got.imm));
            check({tag, "_src_reg_a"}, src_reg_a, got.a);
            check({tag, "_src_reg_b"}, src_reg_b, got.b);
            check({tag, "_src_reg_c"}, src_reg_c, got.c);
        end
        check({tag, "_stall_count"}, 128'(stall_count), 128'(exp_stalls));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_op_code"}, 128'(op_code), 128'(0));
        check({tag, "_enable_reg_write"}, 128'(enable_reg_write), 128'(0));
        check({tag, "_dest_reg_addr"}, 128'(dest_reg_addr), 128'(0));
        check({tag, "_instr_format"}, 128'(instr_format), 128'(0));
        check({tag, "_imm_value"}, 128'(imm_value), 128'(0));
        check({tag, "_src_reg_a"}, src_reg_a, 128'(0));
        check({tag, "_src_reg_b"}, src_reg_b, 128'(0));
        check({tag, "_src_reg_c"}, src_reg_c, 128'(0));
        check({tag, "_stall_count"}, 128'(stall_count), 128'(0));
    endtask

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1, 0, 5, 6, 8, 3'b100, 0, 0, 20, 1, 1, D1, 0, 0, 0, 0, 0, DZ, 1, 1, RA, RB, RC};
        vecs[1]  = '{1, 0, 5, 6, 8, 3'b100, 1, 2, 5, 1, 1, D2, 0, 0, 0, 0, 0, DZ, 1, 1, D2, RB, RC};
        vecs[2]  = '{1, 0, 5, 9, 8, 3'b010, 0, 3, 9, 1, 1, D3, 2, 1, 9, 1, 1, D4, 1, 1, RA, D4, RC};
        vecs[3]  = '{1, 0, 5, 9, 8, 3'b010, 0, 1, 9, 1, 1, D3, 2, 1, 9, 1, 1, D4, 1, 1, RA, D3, RC};
        vecs[4]  = '{1, 0, 5, 6, 8, 3'b100, 0, 0, 5, 0, 1, D2, 0, 0, 0, 0, 0, DZ, 1, 1, RA, RB, RC};
        vecs[5]  = '{1, 0, 5, 6, 8, 3'b000, 0, 0, 5, 1, 0, D2, 0, 0, 0, 0, 0, DZ, 1, 1, RA, RB, RC};
        vecs[6]  = '{1, 0, 5, 6, 8, 3'b100, 0, 1, 5, 1, 0, D2, 0, 0, 0, 0, 0, DZ, 0, 0, DZ, DZ, DZ};
        vecs[7]  = '{1, 1, 5, 6, 8, 3'b100, 0, 1, 5, 1, 0, D2, 0, 0, 0, 0, 0, DZ, 1, 0, DZ, DZ, DZ};
        vecs[8]  = '{0, 0, 5, 6, 8, 3'b100, 0, 1, 5, 1, 0, D2, 0, 0, 0, 0, 0, DZ, 1, 0, DZ, DZ, DZ};
        vecs[9]  = '{1, 0, 0, 6, 8, 3'b100, 2, 0, 0, 1, 1, D5, 0, 0, 0, 0, 0, DZ, 1, 1, D5, RB, RC};
        vecs[10] = '{1, 0, 5, 6, 33, 3'b001, 1, 3, 33, 1, 1, D1, 0, 3, 34, 1, 0, D2, 1, 1, RA, RB, D1};
        vecs[11] = '{1, 0, 5, 5, 8, 3'b110, 1, 1, 5, 1, 1, D2, 0, 2, 5, 1, 0, D3, 1, 1, D2, D2, RC};
        vecs[12] = '{1, 0, 5, 5, 8, 3'b100, 0, 0, 5, 1, 0, D2, 1, 3, 5, 1, 1, D3, 0, 0, DZ, DZ, DZ};

        reset           = 1'b0;
        branch_is_taken = 1'b0;
        rf_ra_data      = RA;
        rf_rb_data      = RB;
        rf_rc_data      = RC;
        clear_fwd();
        set_instr(1'b0, '0, '0, 1'b0, '0, 1'b0);

        #12;
        check_all_zero("reset");
        check("reset_in_ready", 128'(in_ready), 128'(1));
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 13; i++) begin
            clear_fwd();
            in_valid            = vecs[i].valid;
            branch_is_taken     = vecs[i].branch;
            in_op_code          = 11'h100 + 11'(i);
            in_instr_format     = 3'd1;
            in_rt               = 7'(16 + i);
            in_enable_reg_write = 1'b0;
            in_imm_value        = 18'h100 + 18'(i);
            in_ra               = vecs[i].ra;
            in_rb               = vecs[i].rb;
            in_rc               = vecs[i].rc;
            {in_uses_ra, in_uses_rb, in_uses_rc} = vecs[i].uses;
            set_fwd(vecs[i].f0u, vecs[i].f0s, vecs[i].f0addr, vecs[i].f0en, vecs[i].f0rdy, vecs[i].f0data);
            if (vecs[i].f1en)
                set_fwd(vecs[i].f1u, vecs[i].f1s, vecs[i].f1addr, vecs[i].f1en, vecs[i].f1rdy, vecs[i].f1data);
            run_cycle($sformatf("v%0d", i), vecs[i].exp_ready,
                      vecs[i].exp_issue ? mk_exp(11'h100 + 11'(i), 3'd1, 7'(16 + i), 1'b0,
                                                 18'h100 + 18'(i), vecs[i].ea, vecs[i].eb, vecs[i].ec)
                                        : bubble());
        end
        branch_is_taken = 1'b0;

        // Back-to-back dependency on the instruction in the output register.
        clear_fwd();
        set_instr(1'b1, 11'h011, 7'd7, 1'b1, 7'd1, 1'b0);
        run_cycle("b2b_prod", 1'b1, mk_exp(11'h011, 3'd2, 7'd7, 1'b1, 18'h2_0011, RA, RB, RC));
        set_instr(1'b1, 11'h012, 7'd8, 1'b0, 7'd7, 1'b1);
        run_cycle("b2b_stall", 1'b0, bubble());
        set_fwd(0, 0, 7'd7, 1'b1, 1'b1, D5);
        run_cycle("b2b_issue", 1'b1, mk_exp(11'h012, 3'd2, 7'd8, 1'b0, 18'h2_0012, D5, RB, RC));

        // Producer found in a unit stage but not ready for two cycles.
        clear_fwd();
        set_fwd(1, 0, 7'd12, 1'b1, 1'b0, D1);
        set_instr(1'b1, 11'h021, 7'd9, 1'b0, 7'd12, 1'b1);
        run_cycle("nr_stall0", 1'b0, bubble());
        clear_fwd();
        set_fwd(1, 1, 7'd12, 1'b1, 1'b0, D1);
        run_cycle("nr_stall1", 1'b0, bubble());
        clear_fwd();
        set_fwd(1, 2, 7'd12, 1'b1, 1'b1, D4);
        run_cycle("nr_issue", 1'b1, mk_exp(11'h021, 3'd2, 7'd9, 1'b0, 18'h2_0021, D4, RB, RC));

        // Flush arriving while stalled.
        clear_fwd();
        set_fwd(2, 2, 7'd20, 1'b1, 1'b0, D2);
        set_instr(1'b1, 11'h031, 7'd10, 1'b0, 7'd20, 1'b1);
        run_cycle("fl_stall", 1'b0, bubble());
        branch_is_taken = 1'b1;
        run_cycle("fl_flush", 1'b1, bubble());
        branch_is_taken = 1'b0;

        // Reset pulse in the middle of a stall.
        clear_fwd();
        set_instr(1'b1, 11'h041, 7'd3, 1'b1, 7'd1, 1'b0);
        run_cycle("rs_prod", 1'b1, mk_exp(11'h041, 3'd2, 7'd3, 1'b1, 18'h2_0041, RA, RB, RC));
        set_instr(1'b1, 11'h042, 7'd4, 1'b0, 7'd3, 1'b1);
        #2;
        check("rs_stall_in_ready", 128'(in_ready), 128'(0));
        #1 reset = 1'b0;
        #1;
        check_all_zero("rs_async");
        exp_stalls = 0;
        @(posedge clock);
        #1;
        check_all_zero("rs_held");
        #2 reset = 1'b1;
        #1;
        check("rs_release_in_ready", 128'(in_ready), 128'(1));
        run_cycle("rs_issue", 1'b1, mk_exp(11'h042, 3'd2, 7'd4, 1'b0, 18'h2_0042, RA, RB, RC));

        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
